// File: rtl/rom_bus_arbiter_if.sv
// Shared-ROM bus bundle: CPU read port, DMA req/ack port and the single ROM port.
// master = the arbiter's view; slave = the CPU/DMA/ROM environment's view.
interface rom_bus_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              cpu_mreq_n;
    logic              cpu_rd_n;
    logic [ADDR_W-1:0] cpu_a;
    logic [7:0]        cpu_di;
    logic              cpu_wait_n;

    logic              dma_req;
    logic [ADDR_W-1:0] dma_a;
    logic [7:0]        dma_d;
    logic              dma_ack;

    logic              rom_ce_n;
    logic              rom_oe_n;
    logic [ADDR_W-1:0] rom_a;
    logic [7:0]        rom_d;

    modport master (
        input  cpu_mreq_n, cpu_rd_n, cpu_a, dma_req, dma_a, rom_d,
        output cpu_di, cpu_wait_n, dma_d, dma_ack, rom_ce_n, rom_oe_n, rom_a
    );

    modport slave (
        output cpu_mreq_n, cpu_rd_n, cpu_a, dma_req, dma_a, rom_d,
        input  cpu_di, cpu_wait_n, dma_d, dma_ack, rom_ce_n, rom_oe_n, rom_a
    );
endinterface

// File: rtl/rom_bus_arbiter.sv
// Round-robin CPU/DMA sharing of one ROM port; data lands WAIT_STATES+2 cycles after the request edge.
// Backpressure: CPU is stretched through cpu_wait_n, DMA holds dma_req until its one-cycle dma_ack.
module rom_bus_arbiter #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              CLK_n,
    input  logic              RESET_n,
    rom_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } grant_t;

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    state_t            state, state_nxt;
    grant_t            grant, grant_nxt;
    grant_t            last_grant, last_grant_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] rom_a, rom_a_nxt;
    logic [7:0]        cpu_di, cpu_di_nxt;
    logic [7:0]        dma_d, dma_d_nxt;
    logic              cpu_served, cpu_served_nxt;

    logic              cpu_act;
    logic              cpu_pend;
    logic              cpu_done;
    logic              pick_cpu;
    logic              rom_sel_n;
    logic              dma_ack;

    assign cpu_act  = !bus.cpu_mreq_n && !bus.cpu_rd_n;
    assign cpu_pend = cpu_act && !cpu_served;
    assign cpu_done = (state == ST_DONE) && (grant == GNT_CPU);

    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            state      <= ST_IDLE;
            grant      <= GNT_CPU;
            last_grant <= GNT_DMA;
            cnt        <= 4'd0;
            rom_a      <= '0;
            cpu_di     <= 8'h00;
            dma_d      <= 8'h00;
            cpu_served <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            rom_a      <= rom_a_nxt;
            cpu_di     <= cpu_di_nxt;
            dma_d      <= dma_d_nxt;
            cpu_served <= cpu_served_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        rom_a_nxt      = rom_a;
        cpu_di_nxt     = cpu_di;
        dma_d_nxt      = dma_d;
        cpu_served_nxt = cpu_served;
        pick_cpu       = 1'b0;
        rom_sel_n      = 1'b1;
        dma_ack        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cpu_pend || bus.dma_req) begin
                    // On a tie the side that did not win last time goes first.
                    if (cpu_pend && bus.dma_req) begin
                        pick_cpu = (last_grant == GNT_DMA);
                    end else begin
                        pick_cpu = cpu_pend;
                    end
                    grant_nxt = pick_cpu ? GNT_CPU : GNT_DMA;
                    rom_a_nxt = pick_cpu ? bus.cpu_a : bus.dma_a;
                    cnt_nxt   = WS_INIT;
                    state_nxt = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                rom_sel_n = 1'b0;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    if (grant == GNT_CPU) begin
                        cpu_di_nxt = bus.rom_d;
                    end else begin
                        dma_d_nxt = bus.rom_d;
                    end
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                last_grant_nxt = grant;
                if (grant == GNT_DMA) begin
                    dma_ack = RESET_n;
                end else begin
                    cpu_served_nxt = 1'b1;
                end
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A released request re-arms the CPU side, even if it was released mid-access.
        if (bus.cpu_mreq_n) begin
            cpu_served_nxt = 1'b0;
        end
    end

    assign bus.rom_ce_n   = rom_sel_n;
    assign bus.rom_oe_n   = rom_sel_n;
    assign bus.rom_a      = rom_a;
    assign bus.cpu_di     = cpu_di;
    assign bus.dma_d      = dma_d;
    assign bus.dma_ack    = dma_ack;
    assign bus.cpu_wait_n = !(cpu_act && (!RESET_n || (cpu_pend && !cpu_done)));

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Drives two arbiters (WAIT_STATES=2 and 0) with identical CPU/DMA traffic and
// compares every output each cycle against a transaction-level model.
module tb_rom_bus_arbiter;

    localparam int AW    = 15;
    localparam int ROM_N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cpu_mreq_n;
    logic          cpu_rd_n;
    logic [AW-1:0] cpu_a;
    logic          dma_req;
    logic [AW-1:0] dma_a;
    logic [7:0]    rom_mem [ROM_N];

    int n_chk  = 0;
    int n_pass = 0;

    rom_bus_arbiter_if #(.ADDR_W(AW)) bus_a ();
    rom_bus_arbiter_if #(.ADDR_W(AW)) bus_b ();

    rom_bus_arbiter #(.WAIT_STATES(2), .ADDR_W(AW)) u_dut_ws2 (
        .CLK_n   (clk),
        .RESET_n (rst_n),
        .bus     (bus_a.master)
    );

    rom_bus_arbiter #(.WAIT_STATES(0), .ADDR_W(AW)) u_dut_ws0 (
        .CLK_n   (clk),
        .RESET_n (rst_n),
        .bus     (bus_b.master)
    );

    assign bus_a.cpu_mreq_n = cpu_mreq_n;
    assign bus_a.cpu_rd_n   = cpu_rd_n;
    assign bus_a.cpu_a      = cpu_a;
    assign bus_a.dma_req    = dma_req;
    assign bus_a.dma_a      = dma_a;
    assign bus_b.cpu_mreq_n = cpu_mreq_n;
    assign bus_b.cpu_rd_n   = cpu_rd_n;
    assign bus_b.cpu_a      = cpu_a;
    assign bus_b.dma_req    = dma_req;
    assign bus_b.dma_a      = dma_a;

    // ROM model: 16 bytes, zero beyond, 0xFF on the bus when deselected.
    assign bus_a.rom_d = (!bus_a.rom_ce_n && !bus_a.rom_oe_n)
                       ? ((bus_a.rom_a < AW'(ROM_N)) ? rom_mem[bus_a.rom_a[3:0]] : 8'h00) : 8'hFF;
    assign bus_b.rom_d = (!bus_b.rom_ce_n && !bus_b.rom_oe_n)
                       ? ((bus_b.rom_a < AW'(ROM_N)) ? rom_mem[bus_b.rom_a[3:0]] : 8'h00) : 8'hFF;

    logic [1:0]         d_ce_n, d_oe_n, d_ack, d_wait_n;
    logic [1:0][7:0]    d_cpu_di, d_dma_d;
    logic [1:0][AW-1:0] d_rom_a;

    assign d_ce_n   = {bus_b.rom_ce_n,   bus_a.rom_ce_n};
    assign d_oe_n   = {bus_b.rom_oe_n,   bus_a.rom_oe_n};
    assign d_ack    = {bus_b.dma_ack,    bus_a.dma_ack};
    assign d_wait_n = {bus_b.cpu_wait_n, bus_a.cpu_wait_n};
    assign d_cpu_di = {bus_b.cpu_di,     bus_a.cpu_di};
    assign d_dma_d  = {bus_b.dma_d,      bus_a.dma_d};
    assign d_rom_a  = {bus_b.rom_a,      bus_a.rom_a};

    function automatic int ws_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [7:0] rom_val(input logic [AW-1:0] a);
        return (a < AW'(ROM_N)) ? rom_mem[a[3:0]] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction model: an access is "busy" for age 0..ws with the ROM enabled,
    // then one completion cycle at age ws+1; who: 0=CPU, 1=DMA.
    bit [1:0]      m_busy, m_who, m_last, m_served;
    int            m_age    [2];
    logic [AW-1:0] m_addr   [2];
    logic [7:0]    m_cpu_di [2];
    logic [7:0]    m_dma_d  [2];

    task automatic model_step();
        int  ws;
        bit  act, pend, comp, srv;
        for (int i = 0; i < 2; i++) begin
            ws = ws_of(i);
            if (!rst_n) begin
                m_busy[i] = 1'b0; m_age[i] = 0; m_last[i] = 1'b1; m_served[i] = 1'b0;
                m_addr[i] = '0; m_cpu_di[i] = 8'h00; m_dma_d[i] = 8'h00;
            end else begin
                act  = !cpu_mreq_n && !cpu_rd_n;
                pend = act && !m_served[i];
                comp = m_busy[i] && (m_age[i] == ws + 1);
                srv  = m_served[i];
                if (comp && m_who[i] == 1'b0) srv = 1'b1;
                if (cpu_mreq_n) srv = 1'b0;
                if (!m_busy[i]) begin
                    if (pend || dma_req) begin
                        if (pend && dma_req) m_who[i] = !m_last[i];
                        else                 m_who[i] = !pend;
                        m_addr[i] = m_who[i] ? dma_a : cpu_a;
                        m_busy[i] = 1'b1;
                        m_age[i]  = 0;
                    end
                end else begin
                    if (m_age[i] == ws) begin
                        if (m_who[i]) m_dma_d[i]  = rom_val(m_addr[i]);
                        else          m_cpu_di[i] = rom_val(m_addr[i]);
                    end
                    if (comp) begin
                        m_busy[i] = 1'b0;
                        m_last[i] = m_who[i];
                    end else begin
                        m_age[i]++;
                    end
                end
                m_served[i] = srv;
            end
        end
    endtask

    task automatic compare_all();
        int ws;
        bit en, comp, act;
        for (int i = 0; i < 2; i++) begin
            ws   = ws_of(i);
            en   = m_busy[i] && (m_age[i] <= ws);
            comp = m_busy[i] && (m_age[i] == ws + 1);
            act  = !cpu_mreq_n && !cpu_rd_n;
            chk($sformatf("ce_n[%0d]", i),   32'(d_ce_n[i]),   32'(!en));
            chk($sformatf("oe_n[%0d]", i),   32'(d_oe_n[i]),   32'(!en));
            chk($sformatf("rom_a[%0d]", i),  32'(d_rom_a[i]),  32'(m_addr[i]));
            chk($sformatf("cpu_di[%0d]", i), 32'(d_cpu_di[i]), 32'(m_cpu_di[i]));
            chk($sformatf("dma_d[%0d]", i),  32'(d_dma_d[i]),  32'(m_dma_d[i]));
            chk($sformatf("dma_ack[%0d]", i), 32'(d_ack[i]),
                32'(comp && m_who[i] && rst_n));
            chk($sformatf("wait_n[%0d]", i), 32'(d_wait_n[i]),
                32'(!(act && (!rst_n || (!m_served[i] && !(comp && !m_who[i]))))));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic cpu_idle();
        cpu_mreq_n = 1'b1;
        cpu_rd_n   = 1'b1;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a);
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        cpu_a      = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    int first_ack [2];
    int second_ack[2];
    int cnt_a     [2];
    int cnt_b     [2];

    initial begin
        for (int i = 0; i < ROM_N; i++) rom_mem[i] = 8'($urandom_range(1, 255));
        rom_mem[3] = 8'h5A;
        rom_mem[5] = 8'hA5;
        cpu_idle();
        cpu_a   = '0;
        dma_req = 1'b0;
        dma_a   = '0;

        // Reset state
        do_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ce_n",   32'(d_ce_n[i]),   32'h1);
            chk("rst_rom_a",  32'(d_rom_a[i]),  32'h0);
            chk("rst_cpu_di", 32'(d_cpu_di[i]), 32'h0);
            chk("rst_dma_ack", 32'(d_ack[i]),   32'h0);
        end

        // Lone CPU read of address 3, request held afterwards
        cpu_read(AW'(3));
        #1;
        for (int i = 0; i < 2; i++) chk("t1_wait_grant", 32'(d_wait_n[i]), 32'h0);
        cnt_a = '{0, 0};
        cnt_b = '{0, 0};
        for (int n = 0; n < 10; n++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!d_ce_n[i])   cnt_a[i]++;
                if (!d_wait_n[i]) cnt_b[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("t1_ce_cycles",   32'(cnt_a[i]),     32'(ws_of(i) + 1));
            chk("t1_wait_cycles", 32'(cnt_b[i] + 1), 32'(ws_of(i) + 2));
            chk("t1_cpu_di",      32'(d_cpu_di[i]),  32'h5A);
        end
        cpu_idle();
        ticks(2);

        // DMA streaming from address 5
        dma_req = 1'b1;
        dma_a   = AW'(5);
        first_ack  = '{-1, -1};
        second_ack = '{-1, -1};
        for (int n = 1; n <= 12; n++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (d_ack[i]) begin
                    if (first_ack[i] < 0)       first_ack[i]  = n;
                    else if (second_ack[i] < 0) second_ack[i] = n;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("t2_first_ack",  32'(first_ack[i]),  32'(ws_of(i) + 2));
            chk("t2_second_ack", 32'(second_ack[i]), 32'(2 * ws_of(i) + 5));
            chk("t2_dma_d",      32'(d_dma_d[i]),    32'hA5);
        end
        dma_req = 1'b0;
        ticks(8);

        // Same-cycle ties alternate, CPU first after reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cpu_read(AW'(1));
            dma_req = 1'b1;
            dma_a   = AW'(2);
            tick();
            for (int i = 0; i < 2; i++) begin
                chk("t3_tie_ce",     32'(d_ce_n[i]),  32'h0);
                chk("t3_tie_winner", 32'(d_rom_a[i]), (k % 2 == 0) ? 32'h1 : 32'h2);
            end
            cpu_idle();
            dma_req = 1'b0;
            ticks(8);
        end

        // Out-of-range address reads as zero with normal timing
        cpu_read(AW'(16'h0010));
        ticks(4);
        for (int i = 0; i < 2; i++) begin
            chk("t4_cpu_di", 32'(d_cpu_di[i]), 32'h0);
            chk("t4_wait_n", 32'(d_wait_n[i]), 32'h1);
        end
        cpu_idle();
        ticks(2);

        // Reset during the second ACCESS cycle of a DMA read
        dma_req = 1'b1;
        dma_a   = AW'(5);
        ticks(2);
        rst_n   = 1'b0;
        dma_req = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("t5_ce_after_rst",  32'(d_ce_n[i]),  32'h1);
            chk("t5_dma_d_cleared", 32'(d_dma_d[i]), 32'h0);
        end
        rst_n = 1'b1;
        cnt_a = '{0, 0};
        for (int n = 0; n < 5; n++) begin
            tick();
            if (d_ack[0]) cnt_a[0]++;
        end
        chk("t5_no_ack", 32'(cnt_a[0]), 32'h0);
        dma_req   = 1'b1;
        first_ack = '{-1, -1};
        for (int n = 1; n <= 6; n++) begin
            tick();
            for (int i = 0; i < 2; i++) if (d_ack[i] && first_ack[i] < 0) first_ack[i] = n;
        end
        for (int i = 0; i < 2; i++) begin
            chk("t5_retry_ack",   32'(first_ack[i]), 32'(ws_of(i) + 2));
            chk("t5_retry_dma_d", 32'(d_dma_d[i]),   32'hA5);
        end
        dma_req = 1'b0;
        ticks(8);

        // Zero wait states: CPU drops mreq during its single ACCESS cycle
        cpu_read(AW'(3));
        tick();
        chk("t6_ws0_access", 32'(d_ce_n[1]), 32'h0);
        cpu_idle();
        tick();
        chk("t6_ws0_wait_n", 32'(d_wait_n[1]), 32'h1);
        chk("t6_ws0_cpu_di", 32'(d_cpu_di[1]), 32'h5A);
        ticks(6);
        cpu_read(AW'(3));
        tick();
        chk("t6_ws0_reaccess", 32'(d_ce_n[1]), 32'h0);
        cpu_idle();
        ticks(6);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            if (!cpu_mreq_n) begin
                if ($urandom_range(0, 5) == 0) cpu_idle();
            end else if ($urandom_range(0, 3) == 0) begin
                cpu_mreq_n = 1'b0;
                cpu_rd_n   = ($urandom_range(0, 7) == 0);
                cpu_a      = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, ROM_N - 1))
                                                         : AW'($urandom);
            end
            if (dma_req) begin
                if ($urandom_range(0, 4) == 0) dma_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                dma_req = 1'b1;
                dma_a   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, ROM_N - 1))
                                                      : AW'($urandom);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
